// File: rtl/mc_control_fsm.sv
// Main controller for the multi-cycle RV32I datapath: a Moore FSM that drives every
// write enable and mux select, with a memory-ready stall handshake plus retire/illegal pulses.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       adr_src,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       instr_retire,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state;
  state_t     next;
  logic [2:0] alu_dec;
  logic       alu_f3_ok;
  logic       br_f3_ok;

  always_ff @(posedge clk) begin
    if (!rstn) state <= FETCH;
    else       state <= next;
  end

  // funct3 legality is checked here so DECODE can reject encodings before any side effect
  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE: imm_src = 2'b01;
      OP_BR:    imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  always_comb begin
    next          = FETCH;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    adr_src       = 1'b0;
    alu_control   = ALU_ADD;
    instr_retire  = 1'b0;
    illegal_instr = 1'b0;
    state_dbg     = state;
    case (state)
      FETCH: begin
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (opcode)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_R:   if (alu_f3_ok) next = EXECR;  else illegal_instr = 1'b1;
          OP_I:   if (alu_f3_ok) next = EXECI;  else illegal_instr = 1'b1;
          OP_BR:  if (br_f3_ok)  next = BRANCH; else illegal_instr = 1'b1;
          OP_JAL: next = JAL;
          default: illegal_instr = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        next      = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src   = 2'd1;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      MEMWRITE: begin
        adr_src      = 1'b1;
        mem_write    = 1'b1;
        instr_retire = mem_ready;
        next         = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a   = 2'd2;
        alu_control = alu_dec;
        next        = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_dec;
        next        = ALUWB;
      end
      ALUWB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      BRANCH: begin
        alu_src_a    = 2'd2;
        alu_control  = ALU_SUB;
        instr_retire = 1'b1;
        if (funct3 == 3'b000)      pc_write = zero_flag;
        else if (funct3 == 3'b001) pc_write = ~zero_flag;
      end
      JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        next      = ALUWB;
      end
      default: next = FETCH;
    endcase
    // Reset aborts whatever is in flight: nothing but the immediate decode may leak out
    if (!rstn) begin
      next          = FETCH;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'd0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      adr_src       = 1'b0;
      alu_control   = ALU_ADD;
      instr_retire  = 1'b0;
      illegal_instr = 1'b0;
      state_dbg     = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each driven cycle pushes a hand-computed output
// vector; a negedge monitor pops and compares it against the DUT.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, reg_write, mem_write, ir_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_retire, illegal_instr;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, rw, mw, irw;
    logic [1:0] rs, sa, sb;
    logic       adr;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ret, ill;
  } exp_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  mc_control_fsm dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .adr_src(adr_src), .alu_control(alu_control), .imm_src(imm_src),
    .instr_retire(instr_retire), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int st, pcw, rw, mw, irw, rs, sa, sb, adr, alu, imm, ret, ill);
    exp_t e;
    e.st = 4'(st); e.pcw = 1'(pcw); e.rw = 1'(rw); e.mw = 1'(mw); e.irw = 1'(irw);
    e.rs = 2'(rs); e.sa = 2'(sa); e.sb = 2'(sb); e.adr = 1'(adr); e.alu = 3'(alu);
    e.imm = 2'(imm); e.ret = 1'(ret); e.ill = 1'(ill);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic f75, input logic z, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rstn = r; opcode = op; funct3 = f3; funct7_5 = f75; zero_flag = z; mem_ready = rdy;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t want, got;
      want = q.pop_front();
      got = '{state_dbg, pc_write, reg_write, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, adr_src, alu_control, imm_src, instr_retire, illegal_instr};
      total++;
      step++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL step%0d state/ctrl got=%h want=%h", step, got, want);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // Reset cycle: only imm_src is live
    cyc(0, OP_STORE, 3'b000, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,1,0,0));
    // R-type sub
    cyc(1, OP_R, 3'b000, 1, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_R, 3'b000, 1, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,0));
    cyc(1, OP_R, 3'b000, 1, 0, 1, mk(6,0,0,0,0,0,2,0,0,1,0,0,0));
    cyc(1, OP_R, 3'b000, 1, 0, 1, mk(8,0,1,0,0,0,0,0,0,0,0,1,0));
    // R-type and
    cyc(1, OP_R, 3'b111, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_R, 3'b111, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,0));
    cyc(1, OP_R, 3'b111, 0, 0, 1, mk(6,0,0,0,0,0,2,0,0,2,0,0,0));
    cyc(1, OP_R, 3'b111, 0, 0, 1, mk(8,0,1,0,0,0,0,0,0,0,0,1,0));
    // I-type or, then addi with funct7_5 set (still add)
    cyc(1, OP_I, 3'b110, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_I, 3'b110, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,0));
    cyc(1, OP_I, 3'b110, 0, 0, 1, mk(7,0,0,0,0,0,2,1,0,3,0,0,0));
    cyc(1, OP_I, 3'b110, 0, 0, 1, mk(8,0,1,0,0,0,0,0,0,0,0,1,0));
    cyc(1, OP_I, 3'b000, 1, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_I, 3'b000, 1, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,0));
    cyc(1, OP_I, 3'b000, 1, 0, 1, mk(7,0,0,0,0,0,2,1,0,0,0,0,0));
    cyc(1, OP_I, 3'b000, 1, 0, 1, mk(8,0,1,0,0,0,0,0,0,0,0,1,0));
    // lw with two stall cycles in MEMREAD
    cyc(1, OP_LOAD, 3'b010, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 0, mk(3,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 0, mk(3,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 1, mk(3,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc(1, OP_LOAD, 3'b010, 0, 0, 1, mk(4,0,1,0,0,1,0,0,0,0,0,1,0));
    // sw with a FETCH stall and a MEMWRITE stall
    cyc(1, OP_STORE, 3'b010, 0, 0, 0, mk(0,0,0,0,0,2,0,2,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 0, mk(5,0,0,1,0,0,0,0,1,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(5,0,0,1,0,0,0,0,1,0,1,1,0));
    // beq taken, bne not taken, bne taken
    cyc(1, OP_BR, 3'b000, 0, 1, 1, mk(0,1,0,0,1,2,0,2,0,0,2,0,0));
    cyc(1, OP_BR, 3'b000, 0, 1, 1, mk(1,0,0,0,0,0,1,1,0,0,2,0,0));
    cyc(1, OP_BR, 3'b000, 0, 1, 1, mk(9,1,0,0,0,0,2,0,0,1,2,1,0));
    cyc(1, OP_BR, 3'b001, 0, 1, 1, mk(0,1,0,0,1,2,0,2,0,0,2,0,0));
    cyc(1, OP_BR, 3'b001, 0, 1, 1, mk(1,0,0,0,0,0,1,1,0,0,2,0,0));
    cyc(1, OP_BR, 3'b001, 0, 1, 1, mk(9,0,0,0,0,0,2,0,0,1,2,1,0));
    cyc(1, OP_BR, 3'b001, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,2,0,0));
    cyc(1, OP_BR, 3'b001, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,2,0,0));
    cyc(1, OP_BR, 3'b001, 0, 0, 1, mk(9,1,0,0,0,0,2,0,0,1,2,1,0));
    // jal
    cyc(1, OP_JAL, 3'b000, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,3,0,0));
    cyc(1, OP_JAL, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,3,0,0));
    cyc(1, OP_JAL, 3'b000, 0, 0, 1, mk(10,1,0,0,0,0,1,2,0,0,3,0,0));
    cyc(1, OP_JAL, 3'b000, 0, 0, 1, mk(8,0,1,0,0,0,0,0,0,0,3,1,0));
    // Illegal: unknown opcode, bad ALU funct3, bad branch funct3
    cyc(1, 7'b0000000, 3'b000, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, 7'b0000000, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,1));
    cyc(1, OP_I, 3'b001, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,0,0,0));
    cyc(1, OP_I, 3'b001, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0,1));
    cyc(1, OP_BR, 3'b010, 0, 1, 1, mk(0,1,0,0,1,2,0,2,0,0,2,0,0));
    cyc(1, OP_BR, 3'b010, 0, 1, 1, mk(1,0,0,0,0,0,1,1,0,0,2,0,1));
    // sw aborted by reset while in MEMWRITE
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 0, mk(5,0,0,1,0,0,0,0,1,0,1,0,0));
    cyc(0, OP_STORE, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,1,0,0));
    cyc(1, OP_STORE, 3'b010, 0, 0, 1, mk(0,1,0,0,1,2,0,2,0,0,1,0,0));
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Moore-style main controller that sequences the multi-cycle RV32I datapath: fetch, decode, address generation, memory access, execute and write-back. It drives every datapath write enable and mux select from a registered state plus the instruction fields held in the datapath's instruction register. It adds a memory-ready stall handshake, plus retire and illegal-instruction pulses for performance and trap logic.

## Interface

Parameters:
- None.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero_flag  in  1  ALU zero flag, combinational, same cycle
- mem_ready  in  1  memory completes the current access this cycle (tie 1 for single-cycle memory)
- pc_write  out  1  PC register enable
- reg_write  out  1  register-file write enable
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction and old-PC register enable
- result_src  out  2  0 = ALUOut, 1 = memory data, 2 = ALU result
- alu_src_a  out  2  0 = PC, 1 = old PC, 2 = RD1 register, 3 = zero
- alu_src_b  out  2  0 = RD2 register, 1 = immExt, 2 = constant 4
- adr_src  out  1  0 = PC, 1 = Result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- instr_retire  out  1  one-cycle pulse in the final cycle of each legal instruction
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported encoding
- state_dbg  out  4  current state encoding

## Operation

- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10. Codes 11–15 are unreachable and recover to FETCH.
- Default for every state: all enables 0, all selects 0, alu_control = add.
- FETCH:
  - Drives adr_src = 0, alu_src_a = 0, alu_src_b = 2, add, result_src = 2.
  - ir_write = pc_write = mem_ready.
  - Moves to DECODE only when mem_ready = 1; otherwise it stays in FETCH.
- DECODE:
  - Drives alu_src_a = 1, alu_src_b = 1, add, which precomputes the branch/jump target into ALUOut.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL.
  - Any other opcode, or an unsupported funct3 (see ALU decode and BRANCH), pulses illegal_instr and returns to FETCH.
- MEMADR: alu_src_a = 2, alu_src_b = 1, add. Next state is MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 0. Holds until mem_ready, then moves to MEMWB.
- MEMWB: result_src = 1, reg_write = 1, instr_retire = 1. Next state is FETCH.
- MEMWRITE:
  - Drives adr_src = 1, result_src = 0, and holds mem_write = 1 every cycle in the state.
  - When mem_ready is high: instr_retire = 1 and the next state is FETCH.
- EXECR: alu_src_a = 2, alu_src_b = 0, ALU decode. Next state is ALUWB.
- EXECI: alu_src_a = 2, alu_src_b = 1, ALU decode. Next state is ALUWB.
- ALU decode by funct3:
  - 000: sub only if opcode = 0110011 and funct7_5 = 1; otherwise add.
  - 010 → slt; 110 → or; 111 → and.
  - Any other funct3 is illegal and is detected in DECODE.
- ALUWB: result_src = 0, reg_write = 1, instr_retire = 1. Next state is FETCH.
- BRANCH:
  - Drives alu_src_a = 2, alu_src_b = 0, sub, result_src = 0, instr_retire = 1.
  - funct3 000 (beq): pc_write = zero_flag. funct3 001 (bne): pc_write = ~zero_flag. Other funct3 is illegal.
  - Next state is FETCH.
- JAL: alu_src_a = 1, alu_src_b = 2, add, result_src = 0, pc_write = 1. Next state is ALUWB, which writes PC+4 to rd.
- imm_src is combinational from opcode in all states: 0100011 → 01; 1100011 → 10; 1101111 → 11; everything else → 00.

## Timing

- State register updates on the clk rising edge. Outputs are combinational from state, plus opcode/funct fields, zero_flag and mem_ready.
- While rstn = 0:
  - Next state is FETCH.
  - pc_write, reg_write, mem_write, ir_write, instr_retire and illegal_instr are forced to 0.
  - All other outputs read 0, except imm_src, which is decoded from opcode.
  - The first FETCH is the cycle after rstn rises.
- Reset mid-instruction: abort immediately, with no write enable asserted in the reset cycle.
- Cycles with mem_ready held at 1:
  - lw = 5
  - sw = 4
  - R-type and I-type = 4
  - beq/bne = 3
  - jal = 4
- Each cycle mem_ready is low adds exactly one cycle in FETCH, MEMREAD or MEMWRITE; no other state samples mem_ready.
- instr_retire is high in exactly one cycle per legal instruction. illegal_instr and instr_retire are never high together.

## Test plan

- Reset, then mem_ready = 1 and opcode 0110011, funct3 000, funct7_5 = 1 → states 0, 1, 6, 8, 0. alu_control = 001 in EXECR; reg_write and instr_retire high only in ALUWB.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD → states 0, 1, 2, 3, 3, 3, 4, 0. result_src = 1 with reg_write in MEMWB.
- beq with zero_flag = 1, then bne with zero_flag = 1 → pc_write = 1 in BRANCH for beq and 0 for bne. 3 cycles each; imm_src = 10.
- jal → states 0, 1, 10, 8. pc_write high in JAL with alu_src_a = 1, alu_src_b = 2. imm_src = 11.
- Opcode 0000000, and opcode 0010011 with funct3 001 → illegal_instr pulse in DECODE, return to FETCH, no reg_write or mem_write.
- sw with rstn dropped during MEMWRITE → mem_write = 0 in the reset cycle, state_dbg = 0 on the next edge.
